// File: rtl/lab_3_project.sv
// Switch-programmable function generator: a reloadable divider paces an 8-bit
// phase accumulator, which is shaped into one of eight waveforms and then attenuated.
module lab_3_project (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] SW,
    input  logic        ld,
    output logic [7:0]  out_final
);

    typedef enum logic [2:0] {
        WAVE_SAW      = 3'b000,
        WAVE_RSAW     = 3'b001,
        WAVE_TRI      = 3'b010,
        WAVE_SQUARE   = 3'b011,
        WAVE_SINE     = 3'b100,
        WAVE_HALF_SIN = 3'b101,
        WAVE_FULL_SIN = 3'b110,
        WAVE_DC       = 3'b111
    } wave_sel_e;

    logic [7:0] freq_r;
    logic [2:0] wave_r;
    logic [1:0] amp_r;
    logic [7:0] div_cnt_r;
    logic [7:0] phase_r;

    logic       tick_s;
    logic [7:0] wave_s;
    logic [7:0] scaled_s;

    // Parabolic half-arc t*(127-t)/32; the product peaks at 4032 so 12 bits hold it.
    function automatic logic [6:0] half_arc(input logic [6:0] t);
        logic [11:0] prod;
        prod = {5'd0, t} * {5'd0, 7'd127 - t};
        return prod[11:5];
    endfunction

    // Maps a phase value to the unscaled sample of the selected shape.
    function automatic logic [7:0] shape(input logic [2:0] sel, input logic [7:0] ph);
        logic [6:0] t;
        logic [6:0] h;
        logic [7:0] w;
        t = ph[6:0];
        h = half_arc(t);
        case (sel)
            WAVE_SAW:      w = ph;
            WAVE_RSAW:     w = ~ph;
            WAVE_TRI:      w = ph[7] ? ~{t, 1'b0} : {t, 1'b0};
            WAVE_SQUARE:   w = {8{ph[7]}};
            WAVE_SINE:     w = ph[7] ? (8'd128 - {1'b0, h}) : (8'd128 + {1'b0, h});
            WAVE_HALF_SIN: w = ph[7] ? 8'd128 : (8'd128 + {1'b0, h});
            WAVE_FULL_SIN: w = {h, 1'b0};
            WAVE_DC:       w = 8'h80;
            default:       w = 8'h80;
        endcase
        return w;
    endfunction

    // Divider terminal count: one tick per pass through 0xFF.
    always_comb begin
        tick_s = 1'b0;
        if (div_cnt_r == 8'hFF) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Waveform shaping followed by logical-shift attenuation.
    always_comb begin
        wave_s   = shape(wave_r, phase_r);
        scaled_s = wave_s >> amp_r;
    end

    // Configuration capture; a load never touches the divider or phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            freq_r <= 8'h00;
            wave_r <= 3'b000;
            amp_r  <= 2'b00;
        end else if (ld) begin
            freq_r <= SW[7:0];
            wave_r <= SW[10:8];
            amp_r  <= SW[12:11];
        end else begin
            freq_r <= freq_r;
            wave_r <= wave_r;
            amp_r  <= amp_r;
        end
    end

    // Up-counting divider reloaded from freq_r, so the period is 256 - freq_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= 8'h00;
        end else if (tick_s) begin
            div_cnt_r <= freq_r;
        end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
        end
    end

    // Phase accumulator; wraps naturally from 0xFF to 0x00.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r <= 8'h00;
        end else if (tick_s) begin
            phase_r <= phase_r + 8'd1;
        end else begin
            phase_r <= phase_r;
        end
    end

    // Registered sample; reset clears it on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_final <= 8'h00;
        end else begin
            out_final <= scaled_s;
        end
    end

endmodule

// File: tb/tb_lab_3_project.sv
// Directed bench for lab_3_project: each run starts from a reset with ld held,
// then samples out_final at hand-computed edge counts after rst release.
module tb_lab_3_project;

    logic        clk;
    logic        rst;
    logic [12:0] SW;
    logic        ld;
    logic [7:0]  out_final;

    int tests;
    int fails;
    int n;

    lab_3_project dut (
        .clk       (clk),
        .rst       (rst),
        .SW        (SW),
        .ld        (ld),
        .out_final (out_final)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] exp);
        tests++;
        assert (out_final === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d (edge %0d)", tag, out_final, exp, n);
        end
    endtask

    // Advance until 'target' rst-free edges have elapsed; sampling is 1 ns after the edge.
    task automatic adv_to(input int target);
        while (n < target) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_from_reset(input logic [12:0] sw);
        rst = 1'b1;
        ld  = 1'b1;
        SW  = sw;
        @(posedge clk);
        #1;
        check("reset_out", 8'h00);
        rst = 1'b0;
        n   = 0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        n     = 0;
        rst   = 1'b1;
        ld    = 1'b0;
        SW    = 13'h1ABC;
        repeat (2) @(posedge clk);
        #1;

        // Frequency: freq=180, sawtooth. First tick at edge 256, then every 76.
        run_from_reset(13'h00B4);
        adv_to(255); check("freq_pre_tick",  8'd0);
        adv_to(256); check("freq_tick1_lat", 8'd0);
        adv_to(257); check("freq_step1",     8'd1);
        adv_to(332); check("freq_tick2_lat", 8'd1);
        adv_to(333); check("freq_step2",     8'd2);
        adv_to(408); check("freq_tick3_lat", 8'd2);
        adv_to(409); check("freq_step3",     8'd3);

        // Sawtooth with tick every cycle: out after edge n = (n-256) mod 256.
        run_from_reset(13'h00FF);
        adv_to(300); check("saw_44",     8'd44);
        adv_to(511); check("saw_255",    8'd255);
        adv_to(512); check("saw_wrap_0", 8'd0);
        adv_to(513); check("saw_wrap_1", 8'd1);

        // Square full scale then 1/8 scale.
        run_from_reset(13'h03FF);
        adv_to(383); check("sq_lo",  8'h00);
        adv_to(384); check("sq_hi",  8'hFF);
        run_from_reset(13'h1BFF);
        adv_to(383); check("sq8_lo", 8'h00);
        adv_to(384); check("sq8_hi", 8'h1F);

        // Sine approximation.
        run_from_reset(13'h04FF);
        adv_to(256); check("sin_0",   8'd128);
        adv_to(266); check("sin_10",  8'd164);
        adv_to(320); check("sin_64",  8'd254);
        adv_to(384); check("sin_128", 8'd128);
        adv_to(448); check("sin_192", 8'd2);

        // Triangle.
        run_from_reset(13'h02FF);
        adv_to(320); check("tri_64",  8'd128);
        adv_to(383); check("tri_127", 8'd254);
        adv_to(384); check("tri_128", 8'd255);
        adv_to(511); check("tri_255", 8'd1);

        // Remaining shapes and attenuation steps.
        run_from_reset(13'h05FF);
        adv_to(320); check("half_64",  8'd254);
        adv_to(448); check("half_192", 8'd128);
        run_from_reset(13'h06FF);
        adv_to(320); check("full_64",  8'd252);
        adv_to(448); check("full_192", 8'd252);
        run_from_reset(13'h01FF);
        adv_to(256); check("rsaw_0",   8'd255);
        adv_to(320); check("rsaw_64",  8'd191);
        run_from_reset(13'h08FF);
        adv_to(456); check("saw_amp1_200", 8'd100);
        run_from_reset(13'h14FF);
        adv_to(320); check("sin_amp2_64",  8'd63);

        // Reset and load together: load lands on the first edge after rst falls.
        run_from_reset(13'h0780);
        adv_to(1); check("rstld_edge1", 8'd0);
        adv_to(2); check("rstld_edge2", 8'd128);

        // Load gating: SW changes with ld=0 leave shape and frequency alone.
        run_from_reset(13'h00FF);
        adv_to(1);
        ld = 1'b0;
        SW = 13'h0780;
        adv_to(300); check("gate_hold", 8'd44);
        ld = 1'b1;
        adv_to(301); check("gate_ld_edge", 8'd45);
        adv_to(302); check("gate_new_dc",  8'd128);

        // Mid-ramp reset zeroes output on that edge and restarts the ramp.
        run_from_reset(13'h00FF);
        adv_to(300); check("mid_pre", 8'd44);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_zero", 8'd0);
        rst = 1'b0;
        n   = 0;
        adv_to(256); check("mid_restart_0", 8'd0);
        adv_to(257); check("mid_restart_1", 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
